// File: rtl/noc_tg_pkg.sv
// noc_tg_pkg: definitions shared by the NoC traffic generator and its checker.
//   tg_state_t : generator run state (IDLE, SEND, DONE)
//   *_LSB/*_W  : bit positions of the beat payload fields
package noc_tg_pkg;

  typedef enum logic [1:0] {
    TG_IDLE = 2'd0,
    TG_SEND = 2'd1,
    TG_DONE = 2'd2
  } tg_state_t;

  // Payload layout: {zeros, src node, sequence number, beat index}
  localparam int BEAT_LSB = 0;
  localparam int BEAT_W   = 16;
  localparam int SEQ_LSB  = 16;
  localparam int SEQ_W    = 16;
  localparam int SRC_LSB  = 32;

endpackage

// File: rtl/tg_dest_seq.sv
// tg_dest_seq: current-destination register for the traffic generator.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_dest_i (start of a run)
//   load_dest_i  : first destination of the run
//   advance_i    : step to the next node of the round-robin sweep
//   dest_o       : current destination (registered)
module tg_dest_seq #(
  parameter int TDEST_WIDTH      = 4,
  parameter int NUM_NODES        = 16,
  parameter int NODE_ID          = 0,
  parameter int DISABLE_SELFLOOP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [TDEST_WIDTH-1:0] load_dest_i,
  input  logic                   advance_i,
  output logic [TDEST_WIDTH-1:0] dest_o
);

  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [TDEST_WIDTH-1:0] step1, step2;

  function automatic logic [TDEST_WIDTH-1:0] wrap_inc(input logic [TDEST_WIDTH-1:0] d);
    return TDEST_WIDTH'((int'(d) + 1) % NUM_NODES);
  endfunction

  // A second step is enough to skip ourselves because NUM_NODES >= 2.
  assign step1 = wrap_inc(dest_q);
  assign step2 = ((DISABLE_SELFLOOP != 0) && (int'(step1) == NODE_ID)) ? wrap_inc(step1) : step1;

  always_comb begin
    dest_d = dest_q;
    if (load_i) begin
      dest_d = load_dest_i;
    end else if (advance_i) begin
      dest_d = step2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q <= '0;
    end else begin
      dest_q <= dest_d;
    end
  end

  assign dest_o = dest_q;

endmodule

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet source for one NoC input port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, stop          : launch pulse / early-end request (packet boundary)
//   num_packets, pkt_beats, dest_mode, fixed_dest, tid_cfg : run config, sampled on start
//   busy, done, pkts_sent: run status
//   axis_out_*           : AXI-Stream master (tvalid/tready/tdata/tlast/tid/tdest)
module axis_traffic_gen
  import noc_tg_pkg::*;
#(
  parameter int TID_WIDTH        = 2,
  parameter int TDEST_WIDTH      = 4,
  parameter int TDATA_WIDTH      = 512,
  parameter int NODE_ID          = 0,
  parameter int NUM_NODES        = 16,
  parameter int MAX_PKT_BEATS    = 16,
  parameter int DISABLE_SELFLOOP = 1,
  localparam int LEN_W           = $clog2(MAX_PKT_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            num_packets,
  input  logic [LEN_W-1:0]       pkt_beats,
  input  logic                   dest_mode,
  input  logic [TDEST_WIDTH-1:0] fixed_dest,
  input  logic [TID_WIDTH-1:0]   tid_cfg,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            pkts_sent,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  tg_state_t              state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [31:0]            num_q, num_d;
  logic                   mode_q, mode_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [LEN_W-1:0]       beat_q, beat_d;
  logic                   tlast_q, tlast_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [31:0]            pkts_q, pkts_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [LEN_W-1:0]       start_len;
  logic                   hs;
  logic                   dest_load, dest_adv;
  logic [TDEST_WIDTH-1:0] dest;

  function automatic logic [TDATA_WIDTH-1:0] payload(input logic [LEN_W-1:0] beat,
                                                      input logic [SEQ_W-1:0] seq);
    logic [TDATA_WIDTH-1:0] p;
    p = '0;
    p[BEAT_LSB +: BEAT_W]     = BEAT_W'(beat);
    p[SEQ_LSB +: SEQ_W]       = seq;
    p[SRC_LSB +: TDEST_WIDTH] = TDEST_WIDTH'(NODE_ID);
    return p;
  endfunction

  // Zero-length requests become 1-beat packets; oversize requests are clamped.
  always_comb begin
    if (pkt_beats == '0) begin
      start_len = LEN_W'(1);
    end else if (int'(pkt_beats) > MAX_PKT_BEATS) begin
      start_len = LEN_W'(MAX_PKT_BEATS);
    end else begin
      start_len = pkt_beats;
    end
  end

  assign hs = (state_q == TG_SEND) && axis_out_tready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    num_d     = num_q;
    mode_d    = mode_q;
    tid_d     = tid_q;
    beat_d    = beat_q;
    tlast_d   = tlast_q;
    seq_d     = seq_q;
    pkts_d    = pkts_q;
    tdata_d   = tdata_q;
    dest_load = 1'b0;
    dest_adv  = 1'b0;
    case (state_q)
      TG_IDLE: begin
        if (start) begin
          len_d     = start_len;
          num_d     = num_packets;
          mode_d    = dest_mode;
          tid_d     = tid_cfg;
          beat_d    = '0;
          tlast_d   = (start_len == LEN_W'(1));
          seq_d     = '0;
          pkts_d    = '0;
          tdata_d   = payload('0, '0);
          dest_load = 1'b1;
          state_d   = (num_packets == 32'd0) ? TG_DONE : TG_SEND;
        end
      end
      TG_SEND: begin
        if (hs) begin
          if (tlast_q) begin
            beat_d   = '0;
            tlast_d  = (len_q == LEN_W'(1));
            seq_d    = seq_q + SEQ_W'(1);
            pkts_d   = pkts_q + 32'd1;
            dest_adv = mode_q;
            tdata_d  = payload('0, seq_q + SEQ_W'(1));
            // Stop is only honoured here, so packets are never truncated.
            if ((pkts_q + 32'd1 == num_q) || stop) begin
              state_d = TG_DONE;
            end
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            // Precompute tlast for the beat about to be presented.
            tlast_d = (beat_q + LEN_W'(2) == len_q);
            tdata_d = payload(beat_q + LEN_W'(1), seq_q);
          end
        end
      end
      TG_DONE: state_d = TG_IDLE;
      default: state_d = TG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TG_IDLE;
      len_q   <= '0;
      num_q   <= '0;
      mode_q  <= 1'b0;
      tid_q   <= '0;
      beat_q  <= '0;
      tlast_q <= 1'b0;
      seq_q   <= '0;
      pkts_q  <= '0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      mode_q  <= mode_d;
      tid_q   <= tid_d;
      beat_q  <= beat_d;
      tlast_q <= tlast_d;
      seq_q   <= seq_d;
      pkts_q  <= pkts_d;
      tdata_q <= tdata_d;
    end
  end

  tg_dest_seq #(
    .TDEST_WIDTH      (TDEST_WIDTH),
    .NUM_NODES        (NUM_NODES),
    .NODE_ID          (NODE_ID),
    .DISABLE_SELFLOOP (DISABLE_SELFLOOP)
  ) u_dest_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (dest_load),
    .load_dest_i (fixed_dest),
    .advance_i   (dest_adv),
    .dest_o      (dest)
  );

  assign busy            = (state_q != TG_IDLE);
  assign done            = (state_q == TG_DONE);
  assign pkts_sent       = pkts_q;
  assign axis_out_tvalid = (state_q == TG_SEND);
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = dest;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: randomized self-checking bench for axis_traffic_gen.
module tb_axis_traffic_gen;

  localparam int TIDW  = 2;
  localparam int TDW   = 4;
  localparam int DW    = 64;
  localparam int NODE  = 2;
  localparam int NN    = 4;
  localparam int MAXB  = 16;
  localparam int LW    = $clog2(MAXB + 1);

  logic            clk, rst_n, start, stop;
  logic [31:0]     num_packets;
  logic [LW-1:0]   pkt_beats;
  logic            dest_mode;
  logic [TDW-1:0]  fixed_dest;
  logic [TIDW-1:0] tid_cfg;
  logic            busy, done;
  logic [31:0]     pkts_sent;
  logic            tvalid, tready, tlast;
  logic [DW-1:0]   tdata;
  logic [TIDW-1:0] tid;
  logic [TDW-1:0]  tdest;

  axis_traffic_gen #(
    .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .TDATA_WIDTH(DW), .NODE_ID(NODE),
    .NUM_NODES(NN), .MAX_PKT_BEATS(MAXB), .DISABLE_SELFLOOP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .num_packets(num_packets), .pkt_beats(pkt_beats), .dest_mode(dest_mode),
    .fixed_dest(fixed_dest), .tid_cfg(tid_cfg), .busy(busy), .done(done),
    .pkts_sent(pkts_sent), .axis_out_tvalid(tvalid), .axis_out_tready(tready),
    .axis_out_tdata(tdata), .axis_out_tlast(tlast), .axis_out_tid(tid),
    .axis_out_tdest(tdest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: list of every beat the run must emit
  typedef struct {
    logic [DW-1:0]   data;
    logic            last;
    logic [TDW-1:0]  dest;
    logic [TIDW-1:0] tid;
  } beat_t;

  beat_t q[$];
  bit    done_exp  = 1'b0;
  int    pkts_exp  = 0;

  // Observed handshakes (DUT values), cleared by the driver before each run.
  logic [DW-1:0]  hs_data[$];
  logic [TDW-1:0] hs_dest[$];
  logic           hs_last[$];

  task automatic build_run(input int num, input int pb, input bit mode,
                           input int fd, input int tv);
    int    len, d;
    beat_t e;
    len = (pb == 0) ? 1 : ((pb > MAXB) ? MAXB : pb);
    d   = fd;
    for (int p = 0; p < num; p++) begin
      for (int b = 0; b < len; b++) begin
        e.data = '0;
        e.data[15:0]       = 16'(b);
        e.data[31:16]      = 16'(p % 65536);
        e.data[32 +: TDW]  = TDW'(NODE);
        e.last = (b == len - 1);
        e.dest = TDW'(d);
        e.tid  = TIDW'(tv);
        q.push_back(e);
      end
      if (mode) begin
        d = (d + 1) % NN;
        if (d == NODE) d = (d + 1) % NN;
      end
    end
  endtask

  // ---------------- compare process: checks outputs every cycle
  bit             stall_prev = 1'b0;
  logic [DW-1:0]  held_data;
  logic           held_last;
  logic [TDW-1:0] held_dest;

  always @(negedge clk) begin
    bit    nd;
    beat_t e;
    if (!rst_n) begin
      q.delete();
      done_exp   = 1'b0;
      pkts_exp   = 0;
      stall_prev = 1'b0;
    end else begin
      chk("tvalid", 64'(tvalid), 64'(q.size() > 0));
      chk("done", 64'(done), 64'(done_exp));
      chk("busy", 64'(busy), 64'((q.size() > 0) || done_exp));
      chk("pkts_sent", 64'(pkts_sent), 64'(pkts_exp));
      if (tvalid && q.size() > 0) begin
        chk("tdata", 64'(tdata), 64'(q[0].data));
        chk("tlast", 64'(tlast), 64'(q[0].last));
        chk("tdest", 64'(tdest), 64'(q[0].dest));
        chk("tid", 64'(tid), 64'(q[0].tid));
      end
      if (stall_prev && tvalid) begin
        chk("hold_tdata", 64'(tdata), 64'(held_data));
        chk("hold_tlast", 64'(tlast), 64'(held_last));
        chk("hold_tdest", 64'(tdest), 64'(held_dest));
      end
      stall_prev = tvalid && !tready;
      held_data  = tdata;
      held_last  = tlast;
      held_dest  = tdest;

      if (tvalid && tready) begin
        hs_data.push_back(tdata);
        hs_dest.push_back(tdest);
        hs_last.push_back(tlast);
        $display("beat: dest=%0d seq=%0d idx=%0d last=%0b", tdest, tdata[31:16],
                 tdata[15:0], tlast);
      end

      // Predict the next cycle.
      nd = 1'b0;
      if (q.size() > 0) begin
        if (tready) begin
          e = q.pop_front();
          if (e.last) begin
            pkts_exp++;
            if (stop || q.size() == 0) begin
              q.delete();
              nd = 1'b1;
            end
          end
        end
      end else if (!done_exp && start) begin
        pkts_exp = 0;
        build_run(int'(num_packets), int'(pkt_beats), dest_mode, int'(fixed_dest),
                  int'(tid_cfg));
        if (num_packets == 32'd0) nd = 1'b1;
      end
      done_exp = nd;
    end
  end

  // ---------------- tready generator
  int ready_pct = 100;
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- run driver; returns cycles from start+1 to done
  task automatic run(input int num, input int pb, input bit mode, input int fd,
                     input int tv, input int rpct, input int stop_at,
                     input bit rand_stop, input bit start_mid, output int cyc);
    bit got;
    hs_data.delete();
    hs_dest.delete();
    hs_last.delete();
    ready_pct   = rpct;
    num_packets = 32'(num);
    pkt_beats   = LW'(pb);
    dest_mode   = mode;
    fixed_dest  = TDW'(fd);
    tid_cfg     = TIDW'(tv);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    num_packets = $urandom;
    pkt_beats   = LW'($urandom);
    dest_mode   = 1'($urandom);
    fixed_dest  = TDW'($urandom);
    tid_cfg     = TIDW'($urandom);
    got = 1'b0;
    cyc = -1;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin
        got = 1'b1;
        cyc = c;
        break;
      end
      if (stop_at >= 0 && hs_data.size() >= stop_at) stop = 1'b1;
      else if (rand_stop) stop = ($urandom_range(0, 19) == 0);
      start = start_mid && (c == 2);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!got) chk("done_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int exp_rr[4] = '{1, 3, 0, 1};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    num_packets = '0; pkt_beats = '0; dest_mode = 1'b0; fixed_dest = '0; tid_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_tdest", 64'(tdest), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed mode, no backpressure: 3 x 4 beats to node 3.
    run(3, 4, 1'b0, 3, 1, 100, -1, 1'b0, 1'b0, cyc);
    chk("fix_cycles", 64'(cyc), 64'(12));
    chk("fix_beats", 64'(hs_data.size()), 64'(12));
    for (int i = 0; i < hs_data.size(); i++) begin
      chk("fix_dest", 64'(hs_dest[i]), 64'(3));
      chk("fix_last", 64'(hs_last[i]), 64'(i % 4 == 3));
      chk("fix_seq", 64'(hs_data[i][31:16]), 64'(i / 4));
      chk("fix_idx", 64'(hs_data[i][15:0]), 64'(i % 4));
    end
    chk("fix_pkts", 64'(pkts_sent), 64'(3));

    // Round-robin from node 1 skipping ourselves (node 2).
    run(4, 1, 1'b1, 1, 2, 100, -1, 1'b0, 1'b0, cyc);
    chk("rr_beats", 64'(hs_dest.size()), 64'(4));
    for (int i = 0; i < hs_dest.size() && i < 4; i++)
      chk("rr_dest", 64'(hs_dest[i]), 64'(exp_rr[i]));

    // Stop raised at beat 1 of packet 0.
    run(10, 4, 1'b0, 0, 0, 100, 1, 1'b0, 1'b0, cyc);
    chk("stop_beats", 64'(hs_data.size()), 64'(4));
    chk("stop_pkts", 64'(pkts_sent), 64'(1));

    // Zero packets: done in the first cycle after start.
    run(0, 4, 1'b0, 1, 0, 100, -1, 1'b0, 1'b0, cyc);
    chk("zero_cycles", 64'(cyc), 64'(0));
    chk("zero_beats", 64'(hs_data.size()), 64'(0));

    // Zero-length packets become single beats.
    run(3, 0, 1'b0, 1, 3, 100, -1, 1'b0, 1'b0, cyc);
    chk("len0_beats", 64'(hs_data.size()), 64'(3));

    // Oversize packets clamp to 16 beats.
    run(2, 31, 1'b0, 0, 0, 100, -1, 1'b0, 1'b0, cyc);
    chk("clamp_beats", 64'(hs_data.size()), 64'(32));
    if (hs_last.size() == 32) begin
      chk("clamp_last15", 64'(hs_last[15]), 64'(1));
      chk("clamp_last14", 64'(hs_last[14]), 64'(0));
    end

    // Start pulse while busy is ignored.
    run(3, 4, 1'b0, 3, 0, 100, -1, 1'b0, 1'b1, cyc);
    chk("busy_start_beats", 64'(hs_data.size()), 64'(12));

    // Randomised runs with 50% backpressure and random stop.
    for (int r = 0; r < 20; r++) begin
      run($urandom_range(0, 6), $urandom_range(0, 20), 1'($urandom), $urandom_range(0, NN - 1),
          $urandom_range(0, 3), 50, -1, 1'b1, 1'($urandom_range(0, 3) == 0), cyc);
    end

    // Reset in the middle of a packet.
    hs_data.delete();
    ready_pct   = 100;
    num_packets = 32'd5; pkt_beats = LW'(8); dest_mode = 1'b0; fixed_dest = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_tvalid", 64'(tvalid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_tdata", 64'(tdata), 64'(0));
    chk("mrst_pkts", 64'(pkts_sent), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2, 2, 1'b0, 1, 0, 100, -1, 1'b0, 1'b0, cyc);
    chk("post_rst_beats", 64'(hs_data.size()), 64'(4));
    if (hs_data.size() > 0) chk("post_rst_seq0", 64'(hs_data[0][31:16]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
